// File: rtl/fir_seq_ctrl.sv
// Sequencer for the FIR datapath: zero-flush, decimated sample feed, latency tag pipe and
// one-entry output register. Define FIR_SEQ_STATS_EN to build the sample/result counters.
module fir_seq_ctrl #(
  parameter int unsigned TAPS    = 32,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned DW      = 16,
  parameter int unsigned DEC_W   = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DEC_W-1:0] dec_ratio,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DW-1:0]    fir_din,
  output logic             fir_din_valid,
  input  logic [DW-1:0]    fir_dout,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  output logic             busy,
  output logic [1:0]       state,
  output logic [31:0]      sample_cnt,
  output logic [31:0]      result_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam int unsigned FW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [FW-1:0] FlushLast = FW'(TAPS - 1);
  localparam logic [DEC_W-1:0] RatioOne = DEC_W'(1);

  logic [1:0]         state_q, state_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic [DEC_W-1:0]   ratio_q, ratio_d;
  logic [DEC_W-1:0]   dcnt_q, dcnt_d;
  logic [DW-1:0]      fir_din_q, fir_din_d;
  logic               fir_din_valid_q, fir_din_valid_d;
  logic               keep_q, keep_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [DW-1:0]      m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               overrun_q, overrun_d;

  logic hs;
  logic start_acc;
  logic tag_in;
  logic tag_exit;

  assign hs       = s_valid && (state_q == StRun);
  assign tag_in   = fir_din_valid_q && keep_q;
  assign tag_exit = tag_q[LATENCY-1];

  always_comb begin
    state_d         = state_q;
    flush_d         = flush_q;
    ratio_d         = ratio_q;
    dcnt_d          = dcnt_q;
    fir_din_d       = fir_din_q;
    fir_din_valid_d = 1'b0;
    keep_d          = 1'b0;
    start_acc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_acc       = 1'b1;
          state_d         = StFlush;
          flush_d         = '0;
          ratio_d         = (dec_ratio == '0) ? RatioOne : dec_ratio;
          dcnt_d          = '0;
          fir_din_d       = '0;
          fir_din_valid_d = 1'b1;
        end
      end
      StFlush: begin
        fir_din_d = '0;
        flush_d   = flush_q + FW'(1);
        if (flush_q == FlushLast) begin
          state_d = StRun;
        end else begin
          fir_din_valid_d = 1'b1;
        end
      end
      StRun: begin
        if (hs) begin
          fir_din_d       = s_data;
          fir_din_valid_d = 1'b1;
          if (dcnt_q == ratio_q - RatioOne) begin
            keep_d = 1'b1;
            dcnt_d = '0;
          end else begin
            dcnt_d = dcnt_q + RatioOne;
          end
        end
        if (stop) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave only once no kept result is still travelling through the datapath.
        if ((tag_q == '0) && !tag_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = tag_in;
    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    // A new result always wins; it only counts as overrun if the old one was not taken.
    if (tag_exit) begin
      m_data_d  = fir_dout;
      m_valid_d = 1'b1;
      if (m_valid_q && !m_ready) begin
        overrun_d = 1'b1;
      end
    end
    if (start_acc) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= StIdle;
      flush_q         <= '0;
      ratio_q         <= '0;
      dcnt_q          <= '0;
      fir_din_q       <= '0;
      fir_din_valid_q <= 1'b0;
      keep_q          <= 1'b0;
      tag_q           <= '0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_q         <= flush_d;
      ratio_q         <= ratio_d;
      dcnt_q          <= dcnt_d;
      fir_din_q       <= fir_din_d;
      fir_din_valid_q <= fir_din_valid_d;
      keep_q          <= keep_d;
      tag_q           <= tag_d;
      m_data_q        <= m_data_d;
      m_valid_q       <= m_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign s_ready       = (state_q == StRun);
  assign fir_din       = fir_din_q;
  assign fir_din_valid = fir_din_valid_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != StIdle);
  assign state         = state_q;

`ifdef FIR_SEQ_STATS_EN
  logic [31:0] sample_cnt_q;
  logic [31:0] result_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || start_acc) begin
      sample_cnt_q <= '0;
      result_cnt_q <= '0;
    end else begin
      if (hs) begin
        sample_cnt_q <= sample_cnt_q + 32'd1;
      end
      if (tag_exit) begin
        result_cnt_q <= result_cnt_q + 32'd1;
      end
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign result_cnt = result_cnt_q;
`else
  assign sample_cnt = '0;
  assign result_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: a pure delay line stands in for the FIR, and kept results are
// checked against a queue filled from the bench's own decimation model.
module tb_fir_seq_ctrl;

  localparam int unsigned Latency = 6;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        stop;
  logic [7:0]  dec_ratio;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] fir_din;
  logic        fir_din_valid;
  logic [15:0] fir_dout;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        overrun;
  logic        busy;
  logic [1:0]  state;
  logic [31:0] sample_cnt;
  logic [31:0] result_cnt;

  fir_seq_ctrl #(
    .TAPS   (32),
    .LATENCY(Latency),
    .DW     (16),
    .DEC_W  (8)
  ) u_dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .stop         (stop),
    .dec_ratio    (dec_ratio),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .fir_din      (fir_din),
    .fir_din_valid(fir_din_valid),
    .fir_dout     (fir_dout),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overrun      (overrun),
    .busy         (busy),
    .state        (state),
    .sample_cnt   (sample_cnt),
    .result_cnt   (result_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Delay-line stand-in for the datapath.
  logic [15:0] dly_q [Latency];
  always @(posedge sys_clk) begin
    dly_q[0] <= fir_din;
    for (int i = 1; i < int'(Latency); i++) dly_q[i] <= dly_q[i-1];
  end
  assign fir_dout = dly_q[Latency-1];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rcv     = 0;
  int          first_mv = -1;
  int          first_hs = -1;
  int          dcnt    = 0;
  int          eff     = 1;
  logic [15:0] exp_q [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst && m_valid && m_ready) begin
      rcv++;
      if (first_mv < 0) first_mv = cyc;
      if (exp_q.size() == 0) check_val("m_queue_nonempty", exp_q.size(), 1);
      else check_val("m_data", m_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_session(input int ratio, input bit chk_flush);
    int nz;
    bit seen_ready;
    nz = 0;
    seen_ready = 1'b0;
    dec_ratio = 8'(ratio);
    eff = (ratio == 0) ? 1 : ratio;
    dcnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !seen_ready; i++) begin
      @(negedge sys_clk);
      if (s_ready) seen_ready = 1'b1;
      else if (fir_din_valid && fir_din == 16'd0) nz++;
    end
    if (chk_flush) begin
      check_val("flush_cycles", nz, 32);
      check_val("s_ready_after_flush", s_ready, 1);
      check_val("state_run", state, 2);
    end
    tick();
  endtask

  task automatic send(input int n, input int base, input bit push);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(base + i);
      if (first_hs < 0) first_hs = cyc;
      if (push && dcnt == eff - 1) exp_q.push_back(16'(base + i));
      dcnt = (dcnt == eff - 1) ? 0 : dcnt + 1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check_val("drain_queue_left", exp_q.size(), 0);
  endtask

  task automatic end_session();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 60 && state != 2'd0; i++) tick();
    check_val("state_idle_after_stop", state, 0);
  endtask

  initial begin
    int mv_seen;
    sys_rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    dec_ratio = 8'd1;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_state", state, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_fir_din_valid", fir_din_valid, 0);
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_overrun", overrun, 0);
    sys_rst = 1'b0;
    tick();

    // Ratio 1: ten back-to-back samples, each one kept.
    start_session(1, 1'b1);
    rcv = 0; first_hs = -1; first_mv = -1;
    send(10, 1, 1'b1);
    wait_drain();
    check_val("ratio1_count", rcv, 10);
    check_val("first_latency", first_mv - first_hs, 8);
`ifdef FIR_SEQ_STATS_EN
    check_val("sample_cnt", sample_cnt, 10);
    check_val("result_cnt", result_cnt, 10);
`else
    check_val("sample_cnt", sample_cnt, 0);
    check_val("result_cnt", result_cnt, 0);
`endif
    end_session();

    // Ratio 4: keep every fourth.
    start_session(4, 1'b0);
    rcv = 0;
    send(16, 1, 1'b1);
    wait_drain();
    check_val("ratio4_count", rcv, 4);
    end_session();

    // Ratio 0 behaves as 1.
    start_session(0, 1'b0);
    rcv = 0;
    send(5, 1, 1'b1);
    wait_drain();
    check_val("ratio0_count", rcv, 5);
    end_session();

    // Overrun: two results with nobody accepting.
    start_session(1, 1'b0);
    m_ready = 1'b0;
    send(2, 16'h21, 1'b0);
    repeat (15) tick();
    check_val("ovr_flag", overrun, 1);
    check_val("ovr_m_valid", m_valid, 1);
    check_val("ovr_m_data", m_data, 16'h22);
    exp_q.push_back(16'h22);
    m_ready = 1'b1;
    tick();
    check_val("ovr_m_valid_cleared", m_valid, 0);
    check_val("ovr_sticky", overrun, 1);
    end_session();
    start_session(1, 1'b0);
    check_val("ovr_cleared_by_start", overrun, 0);

    // Stop with three samples in flight; the third shares the stop cycle.
    rcv = 0;
    send(2, 16'h31, 1'b1);
    s_valid = 1'b1;
    s_data = 16'h33;
    exp_q.push_back(16'h33);
    stop = 1'b1;
    tick();
    s_valid = 1'b0;
    stop = 1'b0;
    check_val("stop_s_ready", s_ready, 0);
    check_val("stop_state_drain", state, 3);
    for (int i = 0; i < 60 && state != 2'd0; i++) tick();
    check_val("stop_results", rcv, 3);
    check_val("stop_busy", busy, 0);
    check_val("stop_queue_left", exp_q.size(), 0);

    // Reset in RUN discards everything in flight.
    start_session(1, 1'b0);
    send(3, 16'h41, 1'b0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_val("mid_rst_state", state, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_s_ready", s_ready, 0);
    check_val("mid_rst_fir_din_valid", fir_din_valid, 0);
    check_val("mid_rst_fir_din", fir_din, 0);
    check_val("mid_rst_m_data", m_data, 0);
    mv_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m_valid) mv_seen++;
    end
    check_val("mid_rst_no_results", mv_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
